// File: rtl/booth_mul.sv
// Sequential signed 32x32->64 multiplier, radix-4 Booth, two multiplier bits per clock.
// Result appears in hi/lo 16 cycles after start is accepted, flagged by a one-cycle done pulse.
module booth_mul (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [3:0]         r_cnt;
  logic signed [33:0] r_mcand;
  logic signed [33:0] r_acc;
  logic [32:0]        r_q;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_last;
  logic signed [33:0] w_addend;
  logic signed [33:0] w_sum;
  logic signed [33:0] w_acc_sh;
  logic [32:0]        w_q_sh;

  // Booth digit selection; +/-2M needs the full 34 bits so that -2*(-2^31) = +2^32 fits.
  function automatic logic signed [33:0] booth_addend(
    input logic [2:0]         trip,
    input logic signed [33:0] m
  );
    logic signed [33:0] res;
    case (trip)
      3'b001, 3'b010: res = m;
      3'b011:         res = m <<< 1;
      3'b100:         res = -(m <<< 1);
      3'b101, 3'b110: res = -m;
      default:        res = '0;
    endcase
    return res;
  endfunction

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == 4'd15);
  assign w_addend = booth_addend(r_q[2:0], r_mcand);
  assign w_sum    = r_acc + w_addend;
  // {acc, q} shifted right by two as one 67-bit arithmetic shift
  assign w_acc_sh = w_sum >>> 2;
  assign w_q_sh   = {w_sum[1:0], r_q[32:2]};

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = RUN;
      RUN:     if (r_cnt == 4'd15) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_last;
      if (w_accept) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 4'd1;
        r_acc <= w_acc_sh;
        // Product is {acc, q} without the appended y[-1] position.
        if (w_last) begin
          r_hi <= w_acc_sh[31:0];
          r_lo <= w_q_sh[32:1];
        end
      end
    end
  end

  // Operand datapath: loaded on acceptance, shifted during RUN.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand <= {{2{multiplicand[31]}}, multiplicand};
      r_q     <= {multiplier, 1'b0};
    end else if (r_state == RUN) begin
      r_q     <= w_q_sh;
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state == RUN);
  assign done = r_done;

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul: per-cycle comparison against a cycle-level
// behavioural model, directed literal cases, then randomized traffic.
module tb_booth_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit                 m_busy = 1'b0;
  bit                 m_done = 1'b0;
  int                 m_left = 0;
  logic signed [63:0] m_prod = '0;
  logic [31:0]        m_hi   = '0;
  logic [31:0]        m_lo   = '0;

  booth_mul dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: accept when idle, product = plain signed multiply, delivered 16 edges later.
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_prod[63:32];
          m_lo   <= m_prod[31:0];
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= 16;
        m_prod <= $signed({{32{multiplicand[31]}}, multiplicand}) *
                  $signed({{32{multiplier[31]}}, multiplier});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
      if (done === 1'b1 && busy === 1'b1) check("done_and_busy", 1, 0);
      if (done === 1'b1) n_done <= n_done + 1;
    end
  end

  task automatic wait_done(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat);
    bit ok;
    @(posedge clk); #2;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #2;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    wait_done(ok, lat);
    check("op_timeout", ok, 1);
    rh = hi;
    rl = lo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rh, rl, rh2, rl2;
    int lat, d0, e0, c1, c2;
    bit ok;

    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Basic product and latency
    run_op(32'd7, 32'd50, rh, rl, lat);
    check("basic_hi", rh, 32'h0000_0000);
    check("basic_lo", rl, 32'h0000_015E);
    check("basic_busy_cycles", lat, 16);
    repeat (3) @(negedge clk);
    check("hold_hi", hi, 32'h0000_0000);
    check("hold_lo", lo, 32'h0000_015E);

    // Mixed signs, both orders
    run_op(32'd100, 32'hFFFF_FFFA, rh, rl, lat);
    check("mixed_hi", rh, 32'hFFFF_FFFF);
    check("mixed_lo", rl, 32'hFFFF_FDA8);
    run_op(32'hFFFF_FFFA, 32'd100, rh2, rl2, lat);
    check("swap_hi", rh2, rh);
    check("swap_lo", rl2, rl);

    // Extremes
    run_op(32'h8000_0000, 32'h8000_0000, rh, rl, lat);
    check("minmin_hi", rh, 32'h4000_0000);
    check("minmin_lo", rl, 32'h0000_0000);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, rh, rl, lat);
    check("maxmax_hi", rh, 32'h3FFF_FFFF);
    check("maxmax_lo", rl, 32'h0000_0001);
    run_op(32'h8000_0000, 32'd1, rh, rl, lat);
    check("minone_hi", rh, 32'hFFFF_FFFF);
    check("minone_lo", rl, 32'h8000_0000);

    // Start while busy is ignored; operands may change mid-run
    @(posedge clk); #2;
    multiplicand = 32'd3; multiplier = 32'd4; start = 1'b1;
    @(posedge clk); #2;
    e0 = cyc; d0 = n_done; start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    multiplicand = 32'd9; multiplier = 32'd9; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; multiplicand = 32'h1234_5678; multiplier = 32'h8765_4321;
    wait_done(ok, lat);
    check("busy_start_timeout", ok, 1);
    check("busy_start_latency", cyc - e0, 16);
    check("busy_start_hi", hi, 0);
    check("busy_start_lo", lo, 32'd12);
    repeat (20) @(negedge clk);
    check("busy_start_one_done", n_done - d0, 1);

    // Reset mid-operation
    @(posedge clk); #2;
    multiplicand = 32'd50; multiplier = 32'd7; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    d0 = n_done;
    repeat (25) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    run_op(32'd11, 32'd3, rh, rl, lat);
    check("after_abort_hi", rh, 0);
    check("after_abort_lo", rl, 32'd33);

    // Back-to-back with start held high
    @(posedge clk); #2;
    multiplicand = 32'd2; multiplier = 32'd3; start = 1'b1;
    @(posedge clk); #2;
    multiplicand = 32'hFFFF_FFFF; multiplier = 32'hFFFF_FFFF;
    wait_done(ok, lat);
    check("b2b_first_timeout", ok, 1);
    c1 = cyc;
    check("b2b_first_hi", hi, 0);
    check("b2b_first_lo", lo, 32'd6);
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(ok, lat);
    check("b2b_second_timeout", ok, 1);
    c2 = cyc;
    check("b2b_interval", c2 - c1, 17);
    check("b2b_second_hi", hi, 0);
    check("b2b_second_lo", lo, 32'd1);

    // Randomized traffic, checked by the model every cycle
    d0 = n_done;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start        = ($urandom % 4) == 0;
      reset        = ($urandom % 250) == 0;
      multiplicand = pick();
      multiplier   = pick();
    end
    @(posedge clk); #2;
    start = 1'b0; reset = 1'b0;
    repeat (20) @(negedge clk);
    check("random_completions_seen", (n_done - d0) > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul.md
# booth_mul

Sequential signed 32×32→64 multiplier for the ALU's MUL instruction. It is the multiplication counterpart to the sequential divider. It uses radix-4 (modified) Booth recoding and retires two multiplier bits per clock, so a product takes 16 iteration cycles. The result is written into the HI/LO register pair, and a start/busy/done handshake lets the control unit stall for exactly the multiply latency.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit product.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; dominates every other input.
- start  input  1  request; sampled only while idle (busy=0).
- multiplicand  input  32  M, signed two's complement; latched when start is accepted.
- multiplier  input  32  Q, signed two's complement; latched when start is accepted.
- hi  output  32  product[63:32]; registered.
- lo  output  32  product[31:0]; registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  registered pulse, one cycle wide, marking new hi/lo.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - RUN: 4-bit step counter runs 0..15.
- IDLE→RUN on a clock edge where start=1 and reset=0. On that edge:
  - latch M as 34-bit sign-extended mcand;
  - load the multiplier shift register with {Q, 1'b0}, the appended bit being y[-1]=0;
  - clear the 34-bit accumulator and the counter;
  - set busy=1.
- In RUN, each edge examines the low triplet {y[2i+1], y[2i], y[2i-1]} and adds to the accumulator:
  - 000 or 111: 0
  - 001 or 010: +M
  - 011: +2M
  - 100: −2M
  - 101 or 110: −M
- After the add, {accumulator, multiplier register} arithmetic-shifts right 2 bits.
- Width rule: ±2M is formed at 34 bits. This covers M = −2^31, since −2M = +2^32 still fits. The accumulator sign bit is replicated on every shift.
- RUN→IDLE on the edge where counter=15. That edge:
  - loads hi/lo with the final 64-bit product;
  - sets done=1 for exactly one cycle;
  - clears busy.
- hi/lo update only on completion; partial products are never visible. hi/lo hold until the next completion or reset.
- start while busy=1 is ignored: no queueing, no effect on the operation in flight.
- multiplicand and multiplier inputs may change freely after acceptance.
- Reset, at any time including mid-RUN, forces on the next edge:
  - state IDLE, counter 0, accumulator 0;
  - hi=0, lo=0, busy=0, done=0.
  - The aborted operation never asserts done.
- Reset and start high on the same edge: reset wins and the start is dropped.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0.
- Acceptance edge E0. busy is high from E0 through E16 (16 cycles).
- Iteration edges are E1..E16. hi/lo become valid and done is high in the cycle following E16.
- Latency from the start-sampling edge to done visible: 16 cycles.
- done and busy are never high simultaneously.
- Back-to-back operation: start held high during the done cycle is accepted on the next edge. Issue interval is 17 cycles.
- No combinational path from any input to any output.

## Test plan
- Basic product: M=7, Q=50, start for 1 cycle.
  - Response: busy high 16 cycles, then done for one cycle with hi=0x00000000, lo=0x0000015E.
  - hi/lo hold afterwards.
- Mixed signs: M=100, Q=−6 (0xFFFFFFFA).
  - Response: hi=0xFFFFFFFF, lo=0xFFFFFDA8.
  - Repeat with the operands swapped; the result must be identical.
- Extremes:
  - M=Q=0x80000000 → hi=0x40000000, lo=0x00000000.
  - M=Q=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
  - M=0x80000000, Q=1 → hi=0xFFFFFFFF, lo=0x80000000.
- Start while busy: accept 3×4, then pulse start with 9×9 at iteration 5.
  - Response: only one done, 16 cycles after the first acceptance, with lo=12.
  - Changing the input operands mid-RUN also leaves the result at 12.
- Reset mid-operation: start 50×7, assert reset for 1 cycle at iteration 8.
  - Response: next cycle hi=lo=0, busy=0, and no done ever follows.
  - A subsequent 11×3 then yields lo=33 after 16 cycles.
- Back-to-back: start held high continuously with operand pairs 2×3 then −1×−1.
  - Response: done pulses 17 cycles apart, with lo=6 then hi=0, lo=1.
